// File: rtl/bus_arbiter_mux.sv
// Registered N-source bus multiplexer with round-robin arbitration, per-source
// lock hold and a forced-select override; one-cycle latency, one word per cycle.
module bus_arbiter_mux #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned SEL_W   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC-1:0]         req,
  input  logic [NUM_SRC-1:0]         lock,
  input  logic [NUM_SRC*WIDTH-1:0]   data_in,
  input  logic                       force_en,
  input  logic [SEL_W-1:0]           force_sel,
  output logic [NUM_SRC-1:0]         grant,
  output logic [SEL_W-1:0]           grant_sel,
  output logic [WIDTH-1:0]           bus_out,
  output logic                       bus_valid
);

  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   grant_sel_q, grant_sel_d;
  logic [WIDTH-1:0]   bus_q, bus_d;
  logic               valid_q, valid_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic               forced_q, forced_d;

  logic [2*NUM_SRC-1:0] req_rot;
  logic                 rr_found;
  logic [SEL_W-1:0]     rr_idx;
  logic                 held_req;
  logic                 held_lock;
  logic                 force_ok;
  logic                 win;
  logic [SEL_W-1:0]     win_idx;

  // Rotate requests so bit 0 is the source right after the last winner.
  always_comb begin
    req_rot  = {req, req} >> (32'(last_q) + 32'd1);
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (!rr_found && req_rot[k]) begin
        rr_found = 1'b1;
        rr_idx   = SEL_W'((32'(last_q) + 32'd1 + k) % NUM_SRC);
      end
    end
  end

  // Request/lock of the currently granted source.
  always_comb begin
    held_req  = 1'b0;
    held_lock = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant_sel_q == SEL_W'(i)) begin
        held_req  = req[i];
        held_lock = lock[i];
      end
    end
  end

  // Extra top bit keeps the range check exact when NUM_SRC == 2**SEL_W.
  assign force_ok = ({1'b0, force_sel} < (SEL_W + 1)'(NUM_SRC));

  always_comb begin
    grant_d     = '0;
    valid_d     = 1'b0;
    grant_sel_d = grant_sel_q;
    bus_d       = bus_q;
    last_d      = last_q;
    forced_d    = 1'b0;
    win         = 1'b0;
    win_idx     = grant_sel_q;

    if (force_en) begin
      if (force_ok) begin
        win      = 1'b1;
        win_idx  = force_sel;
        forced_d = 1'b1;
      end
    end else if (valid_q && !forced_q && held_lock && held_req) begin
      win     = 1'b1;
      win_idx = grant_sel_q;
    end else if (rr_found) begin
      win     = 1'b1;
      win_idx = rr_idx;
      last_d  = rr_idx;
    end

    if (win) begin
      valid_d     = 1'b1;
      grant_sel_d = win_idx;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (win_idx == SEL_W'(i)) begin
          grant_d[i] = 1'b1;
          bus_d      = data_in[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Pointer resets to the top index so source 0 has first priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q     <= '0;
      grant_sel_q <= '0;
      bus_q       <= '0;
      valid_q     <= 1'b0;
      last_q      <= SEL_W'(NUM_SRC - 1);
      forced_q    <= 1'b0;
    end else begin
      grant_q     <= grant_d;
      grant_sel_q <= grant_sel_d;
      bus_q       <= bus_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      forced_q    <= forced_d;
    end
  end

  assign grant     = grant_q;
  assign grant_sel = grant_sel_q;
  assign bus_out   = bus_q;
  assign bus_valid = valid_q;

endmodule
